cla_arbiter: RTL and testbench

- Shares one 64-bit S4_CLA adder between two requesters using valid/ready handshakes.
- Round-robin arbitration; operands and result are registered around the combinational adder.
- Returns each SUM on a single response channel, tagged with the requester id.
- Sits between the lab's operand sources and the adder datapath; S4_CLA is used unmodified.

---
 rtl/cla_pkg.sv | 27 ++
 rtl/S4_CLA.sv | 43 ++++
 rtl/cla_arbiter.sv | 107 ++++++++++
 tb/tb_cla_arbiter.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cla_pkg.sv
// Shared constants, state encoding and arbitration helper for the CLA arbiter.
package cla_pkg;

    localparam int CLA_WIDTH = 64;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        EXEC = ST_EXEC,
        RESP = ST_RESP
    } state_t;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

    // Round-robin pick: on a tie the requester that did not win last time goes.
    function automatic logic rr_pick(input logic v0, input logic v1, input logic last);
        if (v0 && v1) begin
            return ~last;
        end
        return v1 ? REQ1 : REQ0;
    endfunction

endpackage

// File: rtl/S4_CLA.sv
// 64-bit adder built from sixteen 4-bit carry-lookahead slices with rippled group carry.
// Carry-out is not exposed; the sum wraps modulo 2^64.
module S4_CLA (
    input  logic [63:0] A,
    input  logic [63:0] B,
    output logic [63:0] SUM
);

    logic [63:0] g;
    logic [63:0] p;
    logic [63:0] c;
    logic [15:0] gc;

    assign g     = A & B;
    assign p     = A ^ B;
    assign gc[0] = 1'b0;

    for (genvar i = 0; i < 16; i++) begin : g_slice
        localparam int LO = 4 * i;

        assign c[LO]   = gc[i];
        assign c[LO+1] = g[LO] | (p[LO] & gc[i]);
        assign c[LO+2] = g[LO+1]
                       | (p[LO+1] & g[LO])
                       | (p[LO+1] & p[LO] & gc[i]);
        assign c[LO+3] = g[LO+2]
                       | (p[LO+2] & g[LO+1])
                       | (p[LO+2] & p[LO+1] & g[LO])
                       | (p[LO+2] & p[LO+1] & p[LO] & gc[i]);

        // The top slice's group carry would be the discarded carry-out.
        if (i < 15) begin : g_carry
            assign gc[i+1] = g[LO+3]
                           | (p[LO+3] & g[LO+2])
                           | (p[LO+3] & p[LO+2] & g[LO+1])
                           | (p[LO+3] & p[LO+2] & p[LO+1] & g[LO])
                           | (p[LO+3] & p[LO+2] & p[LO+1] & p[LO] & gc[i]);
        end
    end

    assign SUM = p ^ c;

endmodule

// File: rtl/cla_arbiter.sv
// Round-robin front end sharing one S4_CLA between two valid/ready requesters.
// One operation in flight: accept, register the sum, then hold it until the consumer takes it.
module cla_arbiter
    import cla_pkg::*;
#(
    parameter int WIDTH = CLA_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             req1_ready,
    output logic             resp_valid,
    output logic             resp_id,
    output logic [WIDTH-1:0] resp_sum,
    input  logic             resp_ready,
    output logic             busy
);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] cla_sum;
    logic             cur_id;
    logic             last_grant;
    logic             grant_id;
    logic             accept;

    S4_CLA u_cla (
        .A   (op_a),
        .B   (op_b),
        .SUM (cla_sum)
    );

    assign grant_id = rr_pick(req0_valid, req1_valid, last_grant);
    assign busy     = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        accept     = 1'b0;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        case (state)
            IDLE: begin
                if (req0_valid || req1_valid) begin
                    accept     = 1'b1;
                    req0_ready = (grant_id == REQ0);
                    req1_ready = (grant_id == REQ1);
                    state_nxt  = EXEC;
                end
            end
            EXEC: begin
                state_nxt = RESP;
            end
            RESP: begin
                if (resp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_a       <= '0;
            op_b       <= '0;
            cur_id     <= REQ0;
            last_grant <= REQ1;
            resp_valid <= 1'b0;
            resp_id    <= REQ0;
            resp_sum   <= '0;
        end else begin
            if (accept) begin
                op_a       <= (grant_id == REQ1) ? req1_a : req0_a;
                op_b       <= (grant_id == REQ1) ? req1_b : req0_b;
                cur_id     <= grant_id;
                last_grant <= grant_id;
            end
            // resp_sum/resp_id only move on EXEC, so they stay put through RESP and after it.
            if (state == EXEC) begin
                resp_sum   <= cla_sum;
                resp_id    <= cur_id;
                resp_valid <= 1'b1;
            end else if (state == RESP && resp_ready) begin
                resp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cla_arbiter.sv
// Self-checking bench for cla_arbiter: transaction-level model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_cla_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid;
    logic [63:0] req0_a;
    logic [63:0] req0_b;
    logic        req0_ready;
    logic        req1_valid;
    logic [63:0] req1_a;
    logic [63:0] req1_b;
    logic        req1_ready;
    logic        resp_valid;
    logic        resp_id;
    logic [63:0] resp_sum;
    logic        resp_ready;
    logic        busy;

    int n_checks = 0;
    int n_err    = 0;

    cla_arbiter #(.WIDTH(64)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_ready (req1_ready),
        .resp_valid (resp_valid),
        .resp_id    (resp_id),
        .resp_sum   (resp_sum),
        .resp_ready (resp_ready),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Transaction model: one op in flight, result visible 2 windows after acceptance,
    // retired on the first window where it is visible and resp_ready is high.
    int          cyc = 0;
    bit          m_inflight = 0;
    int          m_due = 0;
    bit          m_last = 1;
    logic [63:0] m_psum = '0;
    bit          m_pid = 0;
    logic [63:0] m_vsum = '0;
    bit          m_vid = 0;
    logic        hs_id_q[$];
    logic [63:0] hs_sum_q[$];

    always begin
        bit          e_rv, e_r0, e_r1, g;
        logic [63:0] e_sum;
        bit          e_id;
        @(negedge clk);
        #2;
        if (rst) begin
            m_inflight = 0;
            m_last     = 1;
            m_vsum     = '0;
            m_vid      = 0;
        end
        e_rv  = m_inflight && (cyc >= m_due);
        e_sum = e_rv ? m_psum : m_vsum;
        e_id  = e_rv ? m_pid : m_vid;
        g     = (req0_valid && req1_valid) ? !m_last : req1_valid;
        e_r0  = !m_inflight && req0_valid && !g;
        e_r1  = !m_inflight && req1_valid && g;
        chk("mdl_req0_ready", req0_ready, e_r0);
        chk("mdl_req1_ready", req1_ready, e_r1);
        chk("mdl_busy", busy, m_inflight);
        chk("mdl_resp_valid", resp_valid, e_rv);
        chk("mdl_resp_sum", resp_sum, e_sum);
        chk("mdl_resp_id", resp_id, e_id);
        if (!rst) begin
            if (e_rv && resp_ready) begin
                m_inflight = 0;
                m_vsum     = m_psum;
                m_vid      = m_pid;
                hs_id_q.push_back(resp_id);
                hs_sum_q.push_back(resp_sum);
            end else if (!m_inflight && (req0_valid || req1_valid)) begin
                m_inflight = 1;
                m_due      = cyc + 2;
                m_pid      = g;
                m_last     = g;
                m_psum     = g ? req1_a + req1_b : req0_a + req0_b;
            end
        end
        cyc++;
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            req0_valid = 0;
            req1_valid = 0;
        end
    endtask

    function automatic logic [63:0] rnd64();
        case ($urandom_range(0, 7))
            0:       return 64'hFFFF_FFFF_FFFF_FFFF;
            1:       return 64'h0;
            2:       return 64'h1;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int hs_n;
        int busy_cnt;
        int grants[$];
        rst = 1; resp_ready = 1;
        req0_valid = 0; req0_a = '0; req0_b = '0;
        req1_valid = 0; req1_a = '0; req1_b = '0;

        // reset values
        @(negedge clk); #3;
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_resp_sum", resp_sum, 0);
        chk("rst_resp_id", resp_id, 0);
        @(negedge clk); rst = 0;

        // single req0; operands change after acceptance
        idle(2);
        @(negedge clk);
        req0_valid = 1; req0_a = 64'h0000_0800_0000_0101; req0_b = 64'h0020_0000_0000_0002;
        #3 chk("t1_ready0", req0_ready, 1);
        @(negedge clk); req0_valid = 0; req0_a = '1; req0_b = '1;
        #3 chk("t1_model_sum", m_psum, 64'h0020_0800_0000_0103);
        chk("t1_rv_early", resp_valid, 0);
        chk("t1_busy", busy, 1);
        @(negedge clk); #3;
        chk("t1_rv", resp_valid, 1);
        chk("t1_sum", resp_sum, 64'h0020_0800_0000_0103);
        chk("t1_id", resp_id, 0);
        @(negedge clk); #3;
        chk("t1_rv_done", resp_valid, 0);
        chk("t1_sum_hold", resp_sum, 64'h0020_0800_0000_0103);

        // single req1, busy exactly 2 windows
        idle(1);
        @(negedge clk);
        req1_valid = 1; req1_a = 64'h170; req1_b = 64'h608;
        busy_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            #3;
            if (busy) busy_cnt++;
            if (i == 2) begin
                chk("t2_sum", resp_sum, 64'h778);
                chk("t2_id", resp_id, 1);
            end
            @(negedge clk);
            req1_valid = 0;
        end
        chk("t2_busy_cycles", busy_cnt, 2);

        // both valid from reset: alternate 0,1,0,1
        rst = 1;
        idle(2);
        hs_n = hs_sum_q.size();
        rst = 0;
        req0_valid = 1; req0_a = 64'h0209_C10B; req0_b = 64'h0080_1824;
        req1_valid = 1; req1_a = 64'h11;        req1_b = 64'h22;
        for (int i = 0; i < 12; i++) begin
            #3;
            if (req0_ready) grants.push_back(0);
            if (req1_ready) grants.push_back(1);
            @(negedge clk);
        end
        req0_valid = 0; req1_valid = 0;
        chk("t3_grant_count", grants.size(), 4);
        for (int i = 0; i < 4 && i < grants.size(); i++)
            chk($sformatf("t3_grant%0d", i), grants[i], i % 2);
        if (hs_sum_q.size() >= hs_n + 2) begin
            chk("t3_first_id", hs_id_q[hs_n], 0);
            chk("t3_first_sum", hs_sum_q[hs_n], 64'h0289_D92F);
            chk("t3_second_sum", hs_sum_q[hs_n+1], 64'h33);
        end else begin
            chk("t3_resp_count", hs_sum_q.size(), hs_n + 2);
        end

        // wrap
        idle(2);
        @(negedge clk);
        req0_valid = 1; req0_a = 64'hFFFF_FFFF_FFFF_FFFF; req0_b = 64'h1;
        @(negedge clk); req0_valid = 0;
        @(negedge clk); #3;
        chk("t4_rv", resp_valid, 1);
        chk("t4_sum_wrap", resp_sum, 64'h0);

        // backpressure with req1 waiting
        idle(3);
        @(negedge clk);
        resp_ready = 0; req0_valid = 1; req0_a = 64'h1234; req0_b = 64'h4321;
        #3 chk("t5_ready0", req0_ready, 1);
        @(negedge clk);
        req0_valid = 0; req1_valid = 1; req1_a = 64'h5; req1_b = 64'h6;
        #3 chk("t5_ready1_exec", req1_ready, 0);
        for (int i = 0; i < 11; i++) begin
            @(negedge clk); #3;
            chk("t5_rv_hold", resp_valid, 1);
            chk("t5_sum_hold", resp_sum, 64'h5555);
            chk("t5_id_hold", resp_id, 0);
            chk("t5_ready1_hold", req1_ready, 0);
        end
        @(negedge clk); resp_ready = 1;
        #3 chk("t5_rv_release", resp_valid, 1);
        @(negedge clk); #3;
        chk("t5_ready1_grant", req1_ready, 1);
        chk("t5_rv_cleared", resp_valid, 0);
        @(negedge clk); req1_valid = 0;
        idle(4);
        chk("t5_last_sum", hs_sum_q[$], 64'hB);
        chk("t5_last_id", hs_id_q[$], 1);

        // reset mid-EXEC drops the op; req0 wins the tie afterwards
        @(negedge clk);
        req1_valid = 1; req1_a = 64'h100; req1_b = 64'h200;
        @(negedge clk);
        req1_valid = 0; rst = 1;
        #3;
        chk("t6_rv_rst", resp_valid, 0);
        chk("t6_busy_rst", busy, 0);
        hs_n = hs_sum_q.size();
        idle(2);
        rst = 0;
        req0_valid = 1; req0_a = 64'h7; req0_b = 64'h8;
        req1_valid = 1;
        #3;
        chk("t6_tie_ready0", req0_ready, 1);
        chk("t6_tie_ready1", req1_ready, 0);
        @(negedge clk); req0_valid = 0; req1_valid = 0;
        idle(4);
        chk("t6_resp_count", hs_sum_q.size(), hs_n + 1);
        chk("t6_resp_sum", hs_sum_q[$], 64'hF);
        chk("t6_resp_id", hs_id_q[$], 0);

        // randomized traffic
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 149) == 0);
            if (rst) begin
                req0_valid = 0;
                req1_valid = 0;
            end else begin
                req0_valid = ($urandom_range(0, 9) < 6);
                req1_valid = ($urandom_range(0, 9) < 6);
            end
            req0_a = rnd64(); req0_b = rnd64();
            req1_a = rnd64(); req1_b = rnd64();
            resp_ready = ($urandom_range(0, 9) < 7);
        end
        @(negedge clk);
        rst = 0; resp_ready = 1;
        idle(6);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
